peak_report_tx: RTL
===================

# peak_report_tx

Transmit side of the per-channel peak path. The block captures the peak results of one channel (largest peak, second peak and their bin indices) when the detector signals end of frame. It buffers up to two result snapshots and sends each one as a 3-beat AXI-Stream packet toward the DMA/packetiser. The detector never stalls: if the buffer is full, a new snapshot is dropped and the drop is counted.

## Interface
- VALUE_WIDTH, default `VALUE_WIDTH (16): width of peak values.
- INDEX_WIDTH, default `INDEX_WIDTH (16): width of bin indices. VALUE_WIDTH + INDEX_WIDTH must be ≤ 32 (checked at elaboration).
- CHANNEL_ID, default 0: 8-bit channel number placed in the header.
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- done  in  1  one-cycle pulse at end of frame; peak inputs are valid in the same cycle.
- peak1_i, peak2_i  in  VALUE_WIDTH  largest and second peak values.
- index1_i, index2_i  in  INDEX_WIDTH  bin indices of the two peaks.
- m_tdata  out  32  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  high on the final beat of a packet.
- dropped_count  out  8  saturating count of dropped snapshots; cleared only by reset.

## Operation
- Snapshot buffer: 2-entry FIFO. Each entry holds {frame_no[15:0], drop_flag, peak1, index1, peak2, index2}.
- On done:
  - If the FIFO is not full, or a pop happens in the same cycle, push {frame_ctr, drop_pending, inputs} and clear drop_pending.
  - Otherwise drop the snapshot: set drop_pending and increment dropped_count, saturating at 255.
  - frame_ctr increments on every done pulse, including dropped ones, and wraps 0xFFFF→0. Dropped frames therefore show up as gaps in frame_no.
- FSM states: IDLE, HDR, P1, P2.
  - IDLE: if the FIFO is non-empty, latch the head into the output register and go to HDR. Otherwise stay in IDLE.
  - HDR, P1, P2: m_tvalid=1. Advance only when m_tvalid && m_tready. HDR→P1→P2.
  - P2: on acceptance, pop the FIFO and return to IDLE. There is always a one-cycle bubble between packets.
- Beat formats (MSBs zero-padded):
  - HDR: [31:16] frame_no, [15:8] CHANNEL_ID, [7:1] 0, [0] drop_flag.
  - P1: {pad, index1, peak1}.
  - P2: {pad, index2, peak2}, with m_tlast=1.
- AXI-Stream rules:
  - While m_tvalid=1 and m_tready=0, m_tdata and m_tlast stay stable.
  - m_tvalid is never withdrawn before acceptance, except by reset.
  - m_tvalid does not depend combinationally on m_tready.

## Timing
- Reset values: m_tvalid=0, m_tlast=0, m_tdata=0, dropped_count=0. Also FIFO empty, frame_ctr=0, drop_pending=0, state IDLE.
- Latency: done in cycle N with IDLE and FIFO empty → entry visible in N+1 → m_tvalid=1 with HDR in cycle N+2.
- Minimum packet period is 4 cycles (3 beats + bubble) with m_tready held high.
- done while a packet is in flight: the snapshot goes to the FIFO. The output register is not disturbed.
- done in the same cycle as the P2 pop with the FIFO full: the push succeeds and nothing is dropped.
- Reset mid-packet: m_tvalid drops at the next edge and the packet is abandoned. Downstream is reset by the same signal.
- done asserted during reset: ignored.

## Structure
- Add to constants.vh:
  - header field positions: HDR_FRAME_LSB=16, HDR_CHAN_LSB=8, HDR_DROP_BIT=0;
  - state encodings;
  - PEAK_TX_FIFO_DEPTH=2.
- One sub-module: peak_snap_fifo, a 2-entry register FIFO with push/pop/full/empty and same-cycle push+pop when full. The FSM and beat mux live in the top module.

## Test plan
- Single frame: done with peak1=0x0123/index1=5, peak2=0x0042/index2=40, tready=1 → beats 0x00000000 (CHANNEL_ID=0), 0x00050123, 0x00280042 with tlast on beat 3; tvalid first high 2 cycles after done.
- Backpressure: tready low for 5 cycles on beat P1 → tdata stays 0x00050123 and tvalid stays 1; beat P2 follows the first accepted cycle.
- Overflow: tready=0, four done pulses → frames 0 and 1 are sent; dropped_count=2. If a fifth done arrives after the FIFO drains, its header shows frame_no=4 and drop bit=1.
- Full FIFO plus P2 pop with done in the same cycle → nothing dropped; three packets sent in order, frame_no 0,1,2.
- Reset asserted during beat P1 → tvalid=0 and dropped_count=0 next cycle; the next done produces frame_no=0.
- Frame counter wrap: 65537 done pulses with tready=1 and spacing ≥4 cycles → the last header carries frame_no=0x0000 and drop bit=0.

Source files
------------

// File: rtl/peak_report_tx_pkg.sv
// Shared constants, FSM state type and header packing helper for the
// per-channel peak report transmitter.
package peak_report_tx_pkg;

  localparam int PRT_VALUE_WIDTH    = 16;
  localparam int PRT_INDEX_WIDTH    = 16;
  localparam int FRAME_WIDTH        = 16;
  localparam int HDR_FRAME_LSB      = 16;
  localparam int HDR_CHAN_LSB       = 8;
  localparam int HDR_DROP_BIT       = 0;
  localparam int PEAK_TX_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_P1   = 2'd2,
    ST_P2   = 2'd3
  } tx_state_t;

  // Header beat: frame number on top, channel id in the middle, drop flag at bit 0.
  function automatic logic [31:0] make_header(input logic [FRAME_WIDTH-1:0] frame_no,
                                              input logic [7:0] chan,
                                              input logic drop);
    logic [31:0] hdr;
    hdr = 32'd0;
    hdr[HDR_FRAME_LSB +: FRAME_WIDTH] = frame_no;
    hdr[HDR_CHAN_LSB +: 8]            = chan;
    hdr[HDR_DROP_BIT]                 = drop;
    return hdr;
  endfunction

endpackage

// File: rtl/peak_report_tx_snap_fifo.sv
// Two-entry register FIFO for peak snapshots. Slot 0 is always the head.
// A push together with a pop is accepted even when the FIFO is full.
module peak_snap_fifo
  import peak_report_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_push_data,
  output logic [WIDTH-1:0] o_head_data,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_slot0;
  logic [WIDTH-1:0] r_slot1;
  logic [1:0]       r_count;

  // Occupancy and slot update; a pop shifts slot 1 down into the head.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 2'd0;
      r_slot0 <= {WIDTH{1'b0}};
      r_slot1 <= {WIDTH{1'b0}};
    end else begin
      case (r_count)
        2'd0: begin
          if (i_push) begin
            r_slot0 <= i_push_data;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          if (i_push && i_pop) begin
            r_slot0 <= i_push_data;
          end else if (i_push) begin
            r_slot1 <= i_push_data;
            r_count <= 2'd2;
          end else if (i_pop) begin
            r_count <= 2'd0;
          end
        end
        2'd2: begin
          if (i_pop) begin
            r_slot0 <= r_slot1;
            if (i_push) begin
              r_slot1 <= i_push_data;
            end else begin
              r_count <= 2'd1;
            end
          end
        end
        default: begin
          r_count <= 2'd0;
        end
      endcase
    end
  end

  assign o_head_data = r_slot0;
  assign o_full      = (r_count == 2'(PEAK_TX_FIFO_DEPTH));
  assign o_empty     = (r_count == 2'd0);

endmodule

// File: rtl/peak_report_tx.sv
// Captures per-frame peak results, buffers up to two snapshots and sends
// each as a 3-beat AXI-Stream packet (header, peak1, peak2).
module peak_report_tx
  import peak_report_tx_pkg::*;
#(
  parameter int VALUE_WIDTH = PRT_VALUE_WIDTH,
  parameter int INDEX_WIDTH = PRT_INDEX_WIDTH,
  parameter int CHANNEL_ID  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   done,
  input  logic [VALUE_WIDTH-1:0] peak1_i,
  input  logic [VALUE_WIDTH-1:0] peak2_i,
  input  logic [INDEX_WIDTH-1:0] index1_i,
  input  logic [INDEX_WIDTH-1:0] index2_i,
  output logic [31:0]            m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic [7:0]             dropped_count
);

  localparam int PAIR_W = VALUE_WIDTH + INDEX_WIDTH;
  localparam int SNAP_W = FRAME_WIDTH + 1 + 2 * PAIR_W;

  if (VALUE_WIDTH + INDEX_WIDTH > 32) begin : g_width_check
    $error("peak_report_tx: VALUE_WIDTH + INDEX_WIDTH must not exceed 32");
  end

  tx_state_t               r_state;
  logic [31:0]             r_tdata;
  logic                    r_tvalid;
  logic                    r_tlast;
  logic [2*PAIR_W-1:0]     r_pairs;
  logic [FRAME_WIDTH-1:0]  r_frame_ctr;
  logic                    r_drop_pending;
  logic [7:0]              r_dropped_count;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  logic [SNAP_W-1:0]       w_push_data;
  logic [SNAP_W-1:0]       w_head;
  logic [VALUE_WIDTH-1:0]  w_peak1;
  logic [VALUE_WIDTH-1:0]  w_peak2;
  logic [INDEX_WIDTH-1:0]  w_index1;
  logic [INDEX_WIDTH-1:0]  w_index2;
  logic [31:0]             w_beat_p1;
  logic [31:0]             w_beat_p2;

  // The head leaves only when the last beat is accepted, so a done in that
  // same cycle still finds room even if the FIFO was full.
  assign w_pop       = (r_state == ST_P2) && m_tready;
  assign w_push      = done && (!w_full || w_pop);
  assign w_push_data = {r_frame_ctr, r_drop_pending, peak1_i, index1_i, peak2_i, index2_i};

  peak_snap_fifo #(
    .WIDTH (SNAP_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (w_push_data),
    .o_head_data (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign w_index2 = r_pairs[0 +: INDEX_WIDTH];
  assign w_peak2  = r_pairs[INDEX_WIDTH +: VALUE_WIDTH];
  assign w_index1 = r_pairs[PAIR_W +: INDEX_WIDTH];
  assign w_peak1  = r_pairs[PAIR_W + INDEX_WIDTH +: VALUE_WIDTH];

  // Payload beats: {index, peak} packed low with zero padding above.
  always_comb begin
    w_beat_p1 = 32'd0;
    w_beat_p2 = 32'd0;
    w_beat_p1[PAIR_W-1:0] = {w_index1, w_peak1};
    w_beat_p2[PAIR_W-1:0] = {w_index2, w_peak2};
  end

  // Frame numbering, pending-drop marker and saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_ctr     <= {FRAME_WIDTH{1'b0}};
      r_drop_pending  <= 1'b0;
      r_dropped_count <= 8'd0;
    end else if (done) begin
      r_frame_ctr <= r_frame_ctr + 16'd1;
      if (w_push) begin
        r_drop_pending <= 1'b0;
      end else begin
        r_drop_pending <= 1'b1;
        if (r_dropped_count != 8'hFF) begin
          r_dropped_count <= r_dropped_count + 8'd1;
        end
      end
    end
  end

  // Packet FSM: latch the head, then walk header/P1/P2 on each acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_tdata  <= 32'd0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_pairs  <= {(2*PAIR_W){1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_pairs  <= w_head[2*PAIR_W-1:0];
            r_tdata  <= make_header(w_head[2*PAIR_W+1 +: FRAME_WIDTH], 8'(CHANNEL_ID),
                                    w_head[2*PAIR_W]);
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b0;
            r_state  <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (m_tready) begin
            r_tdata <= w_beat_p1;
            r_state <= ST_P1;
          end
        end
        ST_P1: begin
          if (m_tready) begin
            r_tdata <= w_beat_p2;
            r_tlast <= 1'b1;
            r_state <= ST_P2;
          end
        end
        ST_P2: begin
          if (m_tready) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_tvalid <= 1'b0;
          r_tlast  <= 1'b0;
        end
      endcase
    end
  end

  assign m_tdata       = r_tdata;
  assign m_tvalid      = r_tvalid;
  assign m_tlast       = r_tlast;
  assign dropped_count = r_dropped_count;

endmodule
